// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard handshake bundle.
// master : decode stage / writeback (drives instruction fields, flush, retire)
// slave  : pipe_hazard_ctrl (returns issue/stall, scoreboard, state, stall count)
interface pipe_hazard_ctrl_if;
  logic        fetch_valid_in;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic        rs1_read_in;
  logic        rs2_read_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [4:0]  wb_rd_in;
  logic        wb_write_in;
  logic        flush_in;
  logic        issue_out;
  logic        stall_out;
  logic [31:0] busy_out;
  logic [1:0]  state_out;
  logic [7:0]  stall_cnt_out;

  modport master (
    output fetch_valid_in, rs1_in, rs2_in, rs1_read_in, rs2_read_in,
           rd_in, rd_write_in, wb_rd_in, wb_write_in, flush_in,
    input  issue_out, stall_out, busy_out, state_out, stall_cnt_out
  );

  modport slave (
    input  fetch_valid_in, rs1_in, rs2_in, rs1_read_in, rs2_read_in,
           rd_in, rd_write_in, wb_rd_in, wb_write_in, flush_in,
    output issue_out, stall_out, busy_out, state_out, stall_cnt_out
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Register scoreboard and issue/stall control for an in-order decode stage.
// Ports:
//   req  : pipeline clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of pipe_hazard_ctrl_if (decode fields, writeback
//          retire, flush in; issue/stall, busy scoreboard, FSM state and
//          saturating stall counter out)
module pipe_hazard_ctrl (
  input  logic                 req,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t      r_state;
  logic [31:0] r_busy;
  logic [7:0]  r_stall_cnt;

  logic        w_hz_rs1, w_hz_rs2, w_hz_rd, w_hazard, w_gate;
  logic        w_issue, w_stall;
  logic [31:0] w_busy_nxt;

  // Hazard looks only at the registered scoreboard, so a retire on this
  // edge releases the instruction one cycle later.
  assign w_hz_rs1 = bus.rs1_read_in && (bus.rs1_in != 5'd0) && r_busy[bus.rs1_in];
  assign w_hz_rs2 = bus.rs2_read_in && (bus.rs2_in != 5'd0) && r_busy[bus.rs2_in];
  assign w_hz_rd  = bus.rd_write_in && (bus.rd_in  != 5'd0) && r_busy[bus.rd_in];
  assign w_hazard = bus.fetch_valid_in && (w_hz_rs1 || w_hz_rs2 || w_hz_rd);

  // Nothing issues or stalls during reset, a flush request, or the flush cycle.
  assign w_gate  = !rst && (r_state != FLUSH) && !bus.flush_in;
  assign w_issue = bus.fetch_valid_in && !w_hazard && w_gate;
  assign w_stall = bus.fetch_valid_in &&  w_hazard && w_gate;

  // Clear first, then set, so a same-index set wins. Flush needs no special
  // case: older writes still retire, and sets are blocked since issue is 0.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.wb_write_in && (bus.wb_rd_in != 5'd0))
      w_busy_nxt[bus.wb_rd_in] = 1'b0;
    if (w_issue && bus.rd_write_in && (bus.rd_in != 5'd0))
      w_busy_nxt[bus.rd_in] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge req or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_busy      <= 32'd0;
      r_stall_cnt <= 8'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != 8'hFF))
        r_stall_cnt <= r_stall_cnt + 8'd1;
      if (bus.flush_in)
        r_state <= FLUSH;
      else begin
        case (r_state)
          RUN:     r_state <= w_stall ? STALL : RUN;
          STALL:   r_state <= w_stall ? STALL : RUN;
          FLUSH:   r_state <= RUN;
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign bus.issue_out     = w_issue;
  assign bus.stall_out     = w_stall;
  assign bus.busy_out      = r_busy;
  assign bus.state_out     = r_state;
  assign bus.stall_cnt_out = r_stall_cnt;

endmodule
